ksa_param: RTL and testbench
============================

// Module: ksa_param
// PURPOSE
//  Parametrised ARC4 key-scheduling engine; successor to the fixed 24-bit-key KSA.
//  Optionally fills S[i]=i first, then runs the KSA permutation:
//    j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
//  Runs against an external single-port, synchronous-read S memory.
//  Sits between the init stage and the PRGA in the decrypt/crack datapath.
//  Adds an abort input for the cracking loop.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes (1..32); key byte 0 = key[KEY_BYTES*8-1 -: 8]
//  DATA_W     8  S entry/address width; S has N = 2**DATA_W entries
//  INIT_MODE  1  1: write S[i]=i for all i before KSA; 0: KSA only
// PORTS
//  clk     in   1            rising-edge clock
//  rst     in   1            asynchronous, active-high reset
//  en      in   1            start request; accepted only when rdy=1
//  rdy     out  1            idle and able to accept en
//  abort   in   1            synchronous abort of a running operation
//  key     in   KEY_BYTES*8  key; latched on the accept cycle
//  addr    out  DATA_W       S memory address
//  rddata  in   DATA_W       S read data; valid the cycle after addr is presented
//  wrdata  out  DATA_W       S write data
//  wren    out  1            S write enable
// BEHAVIOUR
//  Reset: one clock clk; rst is asynchronous, active-high.
//   On rst: state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=j=0.
//   Reset mid-operation abandons S contents; no further writes occur.
//  Handshake:
//   Accept when en=1 and rdy=1 at a clock edge; rdy drops the next cycle.
//   key is captured into key_q on accept.
//   en while rdy=0 is ignored; key changes after accept are ignored.
//  States: IDLE, FILL, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J.
//   IDLE  -> FILL if INIT_MODE, else -> RD_I.
//   FILL  : addr=i, wrdata=i, wren=1, one entry per cycle.
//           After i=N-1: -> RD_I with i=0, j=0.
//   RD_I  : addr=i, wren=0.
//   LAT_I : si_q <= rddata;
//           j <= j + rddata + key_q byte kidx (mod N, DATA_W-bit wrap).
//   RD_J  : addr=j.
//   LAT_J : sj_q <= rddata.
//   WR_I  : addr=i, wrdata=sj_q, wren=1.
//   WR_J  : addr=j, wrdata=si_q, wren=1.
//           If i=N-1 -> IDLE (rdy=1 next cycle); else i++, kidx++, -> RD_I.
//  kidx: counter that wraps KEY_BYTES-1 -> 0; no % operator.
//   When DATA_W < 8, the key byte is truncated to its low DATA_W bits.
//  Latency, accept to rdy=1: INIT_MODE*N + 6*N + 1 cycles.
//   Example: DATA_W=8, INIT_MODE=1 gives 256 + 1536 + 1 = 1793.
//  wren is high only in FILL, WR_I and WR_J.
//  i==j: both writes hit the same address; WR_J's value (si_q) wins, so S is unchanged.
//  abort=1 while rdy=0: next cycle state=IDLE, wren=0, rdy=1.
//   abort while rdy=1 has no effect.
//   abort and en both high with rdy=1: en wins.
// STRUCTURE
//  Package arc4_pkg:
//   ksa_state_t enum.
//   function key_byte(key, idx) for the big-endian byte select.
//   Shared with the PRGA.
//  Sub-module arc4_key_sel (combinational byte mux on kidx).
//   No other hierarchy; single always_ff plus output always_comb.
// TESTING (bench models a 2**DATA_W sync-read RAM, 1-cycle read latency)
//  1. rst=1 mid-FILL:
//     -> rdy=1, wren=0, addr=0 with no clock edge; no writes afterwards.
//  2. INIT_MODE=1, en with key=24'h000000:
//     -> writes 0..255 = i.
//     -> KSA iter0 writes addr0<=0 twice; iter1 writes addr1<=1 twice.
//     -> iter2 swaps S[2],S[3] (addr2<=3, addr3<=2).
//  3. key=24'h010203 after fill:
//     -> iter0: j=1, writes addr0<=1, addr1<=0.
//     -> iter1: j=3, writes addr1<=3, addr3<=0.
//  4. Full run, key=24'h00033C, DATA_W=8:
//     -> final S matches reference model.
//     -> rdy returns exactly 1793 cycles after accept.
//  5. abort asserted at cycle 700:
//     -> rdy=1 and wren=0 next cycle.
//     -> a following en restarts from i=0, j=0.
//  6. KEY_BYTES=5, DATA_W=4, INIT_MODE=0, preloaded S:
//     -> S matches model; latency 97 cycles.
//     -> en pulses while busy are ignored.

Source files
------------

// File: rtl/arc4_pkg.sv
// Types and helpers shared by the ARC4 key-scheduling and keystream engines.
package arc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RD_I  = 3'd2,
    ST_LAT_I = 3'd3,
    ST_RD_J  = 3'd4,
    ST_LAT_J = 3'd5,
    ST_WR_I  = 3'd6,
    ST_WR_J  = 3'd7
  } ksa_state_t;

  localparam int KEY_MAX_BYTES = 32;

  // Byte idx of an nbytes-long key held right-aligned in a 256-bit vector; byte 0 is the MSB.
  function automatic logic [7:0] key_byte(input logic [255:0] key, input logic [4:0] idx,
                                          input int nbytes);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < KEY_MAX_BYTES; k++) begin
      if (k == nbytes - 1 - int'(idx)) begin
        b = key[k*8 +: 8];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/arc4_key_sel.sv
// Combinational key byte select on the running key index, resized to the S data width.
module arc4_key_sel
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int OUT_W     = 8
) (
  input  logic [KEY_BYTES*8-1:0] i_key,
  input  logic [4:0]             i_kidx,
  output logic [OUT_W-1:0]       o_key
);

  logic [255:0] w_key_ext;

  // Right-align the key in the fixed-width vector the package helper expects.
  always_comb begin
    w_key_ext                  = {256{1'b0}};
    w_key_ext[KEY_BYTES*8-1:0] = i_key;
    o_key                      = OUT_W'(key_byte(w_key_ext, i_kidx, KEY_BYTES));
  end

endmodule

// File: rtl/ksa_param.sv
// ARC4 key-scheduling engine driving an external single-port, synchronous-read S memory.
module ksa_param
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DATA_W    = 8,
  parameter int INIT_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic                   abort,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [DATA_W-1:0]      addr,
  input  logic [DATA_W-1:0]      rddata,
  output logic [DATA_W-1:0]      wrdata,
  output logic                   wren
);

  localparam logic [DATA_W-1:0] I_LAST = {DATA_W{1'b1}};
  localparam logic [4:0]        K_LAST = 5'(KEY_BYTES - 1);

  ksa_state_t             r_state;
  logic [DATA_W-1:0]      r_i;
  logic [DATA_W-1:0]      r_j;
  logic [DATA_W-1:0]      r_si;
  logic [DATA_W-1:0]      r_sj;
  logic [4:0]             r_kidx;
  logic [KEY_BYTES*8-1:0] r_key;
  logic [DATA_W-1:0]      w_key_add;

  arc4_key_sel #(
    .KEY_BYTES(KEY_BYTES),
    .OUT_W    (DATA_W)
  ) u_key_sel (
    .i_key (r_key),
    .i_kidx(r_kidx),
    .o_key (w_key_add)
  );

  // Sequencer: fill, then one read-read-write-write swap per S entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= {DATA_W{1'b0}};
      r_j     <= {DATA_W{1'b0}};
      r_si    <= {DATA_W{1'b0}};
      r_sj    <= {DATA_W{1'b0}};
      r_kidx  <= 5'd0;
      r_key   <= {(KEY_BYTES*8){1'b0}};
    end else if (r_state != ST_IDLE && abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_key   <= key;
            r_i     <= {DATA_W{1'b0}};
            r_j     <= {DATA_W{1'b0}};
            r_kidx  <= 5'd0;
            r_state <= (INIT_MODE != 0) ? ST_FILL : ST_RD_I;
          end
        end
        ST_FILL: begin
          if (r_i == I_LAST) begin
            r_i     <= {DATA_W{1'b0}};
            r_j     <= {DATA_W{1'b0}};
            r_kidx  <= 5'd0;
            r_state <= ST_RD_I;
          end else begin
            r_i <= r_i + DATA_W'(1);
          end
        end
        ST_RD_I:  r_state <= ST_LAT_I;
        ST_LAT_I: begin
          r_si    <= rddata;
          r_j     <= r_j + rddata + w_key_add;
          r_state <= ST_RD_J;
        end
        ST_RD_J:  r_state <= ST_LAT_J;
        ST_LAT_J: begin
          r_sj    <= rddata;
          r_state <= ST_WR_I;
        end
        ST_WR_I:  r_state <= ST_WR_J;
        ST_WR_J: begin
          if (r_i == I_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_i     <= r_i + DATA_W'(1);
            r_kidx  <= (r_kidx == K_LAST) ? 5'd0 : r_kidx + 5'd1;
            r_state <= ST_RD_I;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decode from the registered state; WR_J lands last so i==j keeps S intact.
  always_comb begin
    rdy    = (r_state == ST_IDLE);
    addr   = {DATA_W{1'b0}};
    wrdata = {DATA_W{1'b0}};
    wren   = 1'b0;
    case (r_state)
      ST_FILL: begin
        addr   = r_i;
        wrdata = r_i;
        wren   = 1'b1;
      end
      ST_RD_I, ST_LAT_I: addr = r_i;
      ST_RD_J, ST_LAT_J: addr = r_j;
      ST_WR_I: begin
        addr   = r_i;
        wrdata = r_sj;
        wren   = 1'b1;
      end
      ST_WR_J: begin
        addr   = r_j;
        wrdata = r_si;
        wren   = 1'b1;
      end
      default: addr = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_ksa_param.sv
// Directed bench for ksa_param: one 3-byte/8-bit/fill instance and one 5-byte/4-bit/no-fill instance.
module tb_ksa_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic        en1, rdy1, abort1, wren1;
  logic [23:0] key1;
  logic [7:0]  addr1, rddata1, wrdata1;

  logic        en2, rdy2, abort2, wren2;
  logic [39:0] key2;
  logic [3:0]  addr2, rddata2, wrdata2;
  logic        pre_we2;
  logic [3:0]  pre_a2, pre_d2;

  ksa_param #(.KEY_BYTES(3), .DATA_W(8), .INIT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .abort(abort1), .key(key1),
    .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1)
  );

  ksa_param #(.KEY_BYTES(5), .DATA_W(4), .INIT_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .abort(abort2), .key(key2),
    .addr(addr2), .rddata(rddata2), .wrdata(wrdata2), .wren(wren2)
  );

  logic [7:0] mem1 [256];
  logic [3:0] mem2 [16];
  logic [7:0] wlog_a [8192];
  logic [7:0] wlog_d [8192];
  int         wcount = 0;
  logic [7:0] ms1 [256];
  logic [3:0] ms2 [16];

  always @(posedge clk) begin
    if (wren1) begin
      mem1[addr1]           <= wrdata1;
      wlog_a[wcount % 8192] <= addr1;
      wlog_d[wcount % 8192] <= wrdata1;
      wcount                <= wcount + 1;
    end
    rddata1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (pre_we2) mem2[pre_a2] <= pre_d2;
    else if (wren2) mem2[addr2] <= wrdata2;
    rddata2 <= mem2[addr2];
  end

  task automatic model1(input logic [23:0] k);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) ms1[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      kb = 8'(k >> ((2 - (i % 3)) * 8));
      j  = j + ms1[i] + kb;
      t = ms1[i]; ms1[i] = ms1[j]; ms1[j] = t;
    end
  endtask

  task automatic start1(input logic [23:0] k);
    @(negedge clk);
    key1 = k;
    en1  = 1'b1;
    @(posedge clk);
    #1;
    en1  = 1'b0;
    key1 = 24'hA5A5A5;
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 1;
    while (rdy1 !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_s1(input logic [23:0] k);
    int errs;
    model1(k);
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem1[i] !== ms1[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL s_final key=%h mismatched=%0d required=0", k, errs);
    end
  endtask

  task automatic test_reset();
    int base;
    total++;
    if (rdy1 !== 1'b1 || wren1 !== 1'b0 || addr1 !== 8'd0 || rdy2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_state rdy=%b wren=%b addr=%h required 1 0 00", rdy1, wren1, addr1);
    end
    start1(24'h000000);
    repeat (50) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (rdy1 !== 1'b1 || wren1 !== 1'b0 || addr1 !== 8'd0) begin
      bad++;
      $display("FAIL async_reset rdy=%b wren=%b addr=%h required 1 0 00", rdy1, wren1, addr1);
    end
    base = wcount;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (wcount !== base) begin
      bad++;
      $display("FAIL reset_no_writes writes=%0d required=0", wcount - base);
    end
  endtask

  task automatic test_zero_key();
    logic [7:0] ea [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    logic [7:0] ed [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
    int base, cyc, errs;
    base = wcount;
    start1(24'h000000);
    wait_done1(cyc);
    errs = 0;
    for (int k = 0; k < 256; k++)
      if (wlog_a[(base + k) % 8192] !== 8'(k) || wlog_d[(base + k) % 8192] !== 8'(k)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL fill_writes bad_entries=%0d required=0", errs);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (wlog_a[(base + 256 + k) % 8192] !== ea[k] || wlog_d[(base + 256 + k) % 8192] !== ed[k]) begin
        bad++;
        $display("FAIL zero_key_wr%0d got %h<=%h required %h<=%h", k,
                 wlog_a[(base + 256 + k) % 8192], wlog_d[(base + 256 + k) % 8192], ea[k], ed[k]);
      end
    end
    check_s1(24'h000000);
  endtask

  task automatic check_010203(input int base, input string tag);
    logic [7:0] ea [4] = '{8'd0, 8'd1, 8'd1, 8'd3};
    logic [7:0] ed [4] = '{8'd1, 8'd0, 8'd3, 8'd0};
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wlog_a[(base + 256 + k) % 8192] !== ea[k] || wlog_d[(base + 256 + k) % 8192] !== ed[k]) begin
        bad++;
        $display("FAIL %s_wr%0d got %h<=%h required %h<=%h", tag, k,
                 wlog_a[(base + 256 + k) % 8192], wlog_d[(base + 256 + k) % 8192], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_key_010203();
    int base, cyc;
    base = wcount;
    start1(24'h010203);
    wait_done1(cyc);
    check_010203(base, "key010203");
    check_s1(24'h010203);
  endtask

  task automatic test_full_run();
    int cyc;
    start1(24'h00033C);
    wait_done1(cyc);
    total++;
    if (cyc !== 1793) begin
      bad++;
      $display("FAIL latency_full got=%0d required=1793", cyc);
    end
    check_s1(24'h00033C);
  endtask

  task automatic test_abort();
    int base, cyc;
    @(negedge clk) abort1 = 1'b1;
    base = wcount;
    @(posedge clk);
    #1 abort1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy1 !== 1'b1 || wcount !== base) begin
      bad++;
      $display("FAIL abort_idle rdy=%b writes=%0d required 1 0", rdy1, wcount - base);
    end
    @(negedge clk);
    key1 = 24'h00033C; en1 = 1'b1; abort1 = 1'b1;
    @(posedge clk);
    #1 en1 = 1'b0; abort1 = 1'b0;
    total++;
    if (rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL en_beats_abort rdy=%b required 0", rdy1);
    end
    repeat (699) @(posedge clk);
    #1 abort1 = 1'b1;
    @(posedge clk);
    #1 abort1 = 1'b0;
    total++;
    if (rdy1 !== 1'b1 || wren1 !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy rdy=%b wren=%b required 1 0", rdy1, wren1);
    end
    base = wcount;
    start1(24'h010203);
    wait_done1(cyc);
    total++;
    if (cyc !== 1793) begin
      bad++;
      $display("FAIL latency_after_abort got=%0d required=1793", cyc);
    end
    check_010203(base, "restart");
  endtask

  task automatic test_small();
    logic [39:0] k;
    logic [3:0]  j, t, kb;
    int          cyc, errs;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we2 = 1'b1; pre_a2 = 4'(i); pre_d2 = 4'((i * 7 + 3) % 16);
      ms2[i] = 4'((i * 7 + 3) % 16);
    end
    @(negedge clk) pre_we2 = 1'b0;
    k = 40'h1FA203C458;
    j = 4'd0;
    for (int i = 0; i < 16; i++) begin
      kb = 4'(k >> ((4 - (i % 5)) * 8));
      j  = j + ms2[i] + kb;
      t = ms2[i]; ms2[i] = ms2[j]; ms2[j] = t;
    end
    @(negedge clk);
    key2 = k; en2 = 1'b1;
    @(posedge clk);
    #1 en2 = 1'b0; key2 = 40'h0;
    cyc = 1;
    while (rdy2 !== 1'b1 && cyc < 500) begin
      if (cyc == 20 || cyc == 60) begin
        en2 = 1'b1; key2 = 40'hFFFFFFFFFF;
      end else begin
        en2 = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    en2 = 1'b0;
    total++;
    if (cyc !== 97) begin
      bad++;
      $display("FAIL latency_small got=%0d required=97", cyc);
    end
    errs = 0;
    for (int i = 0; i < 16; i++) if (mem2[i] !== ms2[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL s_small mismatched=%0d required=0", errs);
    end
  endtask

  initial begin
    rst = 1'b1;
    en1 = 1'b0; abort1 = 1'b0; key1 = 24'h0;
    en2 = 1'b0; abort2 = 1'b0; key2 = 40'h0;
    pre_we2 = 1'b0; pre_a2 = 4'd0; pre_d2 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    test_reset();
    test_zero_key();
    test_key_010203();
    test_full_run();
    test_abort();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
